// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and byte-level helper functions
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_ROUNDS = 10;

  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} aes_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] inv;
    t = x;
    for (int i = 0; i < 6; i++) t = gf_mul(gf_mul(t, t), x);
    inv = gf_mul(t, t);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte 0 is the MSB; column c holds bytes 4c..4c+3, row r is the offset within it.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one AES-128 key expansion step (RotWord, SubWord, RCON, word chaining)
module aes_key_step
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] key_i,
  input  logic [7:0]           rcon_i,
  output logic [AES_BLK_W-1:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;
  assign temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_i, 24'h0};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_last_round.sv
// rtl/aes_last_round.sv - final AES round: SubBytes, ShiftRows, AddRoundKey (no MixColumns)
module aes_last_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_i,
  input  logic [AES_BLK_W-1:0] rk_i,
  output logic [AES_BLK_W-1:0] state_o
);

  assign state_o = sub_shift(state_i) ^ rk_i;

endmodule

// File: rtl/aes_round.sv
// rtl/aes_round.sv - full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey
module aes_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_i,
  input  logic [AES_BLK_W-1:0] rk_i,
  output logic [AES_BLK_W-1:0] state_o
);

  logic [AES_BLK_W-1:0] ss;
  logic [AES_BLK_W-1:0] mixed;

  assign ss = sub_shift(state_i);

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_col(ss[127-32*c -: 32]);
    end
  end

  assign state_o = mixed ^ rk_i;

endmodule

// File: rtl/aes_iter_ctrl.sv
// rtl/aes_iter_ctrl.sv - iterative AES-128 encryptor, one round per cycle; AES_ITER_ABORT_EN adds an abort input
module aes_iter_ctrl
  import aes_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] data_in,
  input  logic [AES_BLK_W-1:0] key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] data_out,
`ifdef AES_ITER_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy
);

  if (ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("aes_iter_ctrl: only ROUNDS=10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_RND = 4'(AES_ROUNDS - 1);

  aes_state_e           state_q, state_d;
  logic [AES_BLK_W-1:0] st_q, st_d;
  logic [AES_BLK_W-1:0] rk_q, rk_d;
  logic [3:0]           rnd_q, rnd_d;

  logic                 abort_w;
  logic                 accept;
  logic                 in_run;
  logic [AES_BLK_W-1:0] ks_in, ks_out;
  logic [AES_BLK_W-1:0] round_out, last_out;
  logic [7:0]           rcon_w;

`ifdef AES_ITER_ABORT_EN
  assign abort_w = abort & (state_q != IDLE);
`else
  assign abort_w = 1'b0;
`endif

  // Gated by rst_n so the handshake stays closed for the whole reset pulse.
  assign in_ready = rst_n & ((state_q == IDLE) |
                             ((state_q == DONE) & out_ready & ~abort_w));
  assign accept   = in_valid & in_ready;

  assign in_run = (state_q == RUN);
  assign ks_in  = in_run ? rk_q : key;
  assign rcon_w = in_run ? rcon((rnd_q > LAST_RND) ? 4'd0 : rnd_q) : rcon(4'd0);

  aes_key_step u_key_step (
    .key_i  (ks_in),
    .rcon_i (rcon_w),
    .key_o  (ks_out)
  );

  aes_round u_round (
    .state_i (st_q),
    .rk_i    (rk_q),
    .state_o (round_out)
  );

  aes_last_round u_last_round (
    .state_i (st_q),
    .rk_i    (rk_q),
    .state_o (last_out)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          st_d    = data_in ^ key;
          rk_d    = ks_out;
          rnd_d   = 4'd1;
          state_d = RUN;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        st_d  = round_out;
        rk_d  = ks_out;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) state_d = LAST;
      end
      LAST: begin
        st_d    = last_out;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_w) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign data_out  = st_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// tb/tb_aes_iter_ctrl.sv - directed vector bench for aes_iter_ctrl
module tb_aes_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [127:0] data_out;
`ifdef AES_ITER_ABORT_EN
  logic         abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  aes_iter_ctrl #(.ROUNDS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
`ifdef AES_ITER_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic scramble();
    data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    key     = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic accept_block(input logic [127:0] k, input logic [127:0] pt, input string nm);
    @(negedge clk);
    in_valid = 1'b1;
    key      = k;
    data_in  = pt;
    check({nm, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, "_idle_out_valid"}, out_valid, 0);
    check({nm, "_idle_busy"}, busy, 0);
  endtask

  task automatic run_vec(input int i, input string nm);
    int n;
    accept_block(vecs[i].key, vecs[i].pt, nm);
    wait_out(n);
    check({nm, "_latency"}, n, 10);
    check({nm, "_data_out"}, data_out, vecs[i].ct);
    release_out(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n2, seen;
    logic rdy_bad;

    vecs[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = {128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[3] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
               128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[4] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
               128'hf5d3d58503b9699de785895a96fdbaaf};
    vecs[5] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf69f2445df4f9b17ad2b417be66c3710,
               128'h7b0c785e27e8ad3f8223207104725dd4};

    // Reset state
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_vec(i, $sformatf("vec%0d", i));
    end

    // Consumer stall: result must hold while out_ready is low
    accept_block(vecs[1].key, vecs[1].pt, "stall");
    wait_out(n);
    check("stall_latency", n, 10);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d_data_out", c), data_out, vecs[1].ct);
      check($sformatf("stall%0d_out_valid", c), out_valid, 1);
      check($sformatf("stall%0d_in_ready", c), in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    release_out("stall");

    // Back-to-back: second accept lands in the DONE cycle of the first
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    key       = vecs[0].key;
    data_in   = vecs[0].pt;
    @(negedge clk);
    key     = vecs[1].key;
    data_in = vecs[1].pt;
    wait_out(n);
    check("b2b_first_latency", n, 10);
    check("b2b_first_data_out", data_out, vecs[0].ct);
    check("b2b_done_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    check("b2b_second_busy", busy, 1);
    wait_out(n2);
    check("b2b_spacing", n2 + 1, 11);
    check("b2b_second_data_out", data_out, vecs[1].ct);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle_out_valid", out_valid, 0);

    // Reset pulse at rnd=5 discards the block in flight
    accept_block(vecs[3].key, vecs[3].pt, "rstmid");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_data_out", data_out, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid_release_in_ready", in_ready, 1);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check("rstmid_no_out_valid", seen, 0);
    run_vec(4, "rstmid_next");

    // in_valid toggling with random data during RUN is ignored
    accept_block(vecs[2].key, vecs[2].pt, "toggle");
    rdy_bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = c[0];
      scramble();
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("toggle_in_ready_low", rdy_bad, 0);
    wait_out(n);
    check("toggle_latency", n + 8, 10);
    check("toggle_data_out", data_out, vecs[2].ct);
    release_out("toggle");

`ifdef AES_ITER_ABORT_EN
    accept_block(vecs[5].key, vecs[5].pt, "abort");
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_out_valid", seen, 0);
    run_vec(5, "abort_next");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_iter_ctrl.md
AES_ITER_CTRL -- requirements
Module: aes_iter_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 10, number of AES rounds; only 10 (AES-128) is legal, and elaboration SHALL fail on any other value.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning data_in/key are valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts a block this cycle.
REQ-006 SHALL have port data_in, input, 128, the plaintext block.
REQ-007 SHALL have port key, input, 128, the cipher key.
REQ-008 SHALL have port out_valid, output, 1, meaning data_out holds a ciphertext.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes data_out.
REQ-010 SHALL have port data_out, output, 128, the ciphertext block.
REQ-011 SHALL have port busy, output, 1, high when state != IDLE.

Function
REQ-012 SHALL sequence one shared round datapath and one shared last-round datapath iteratively; it SHALL NOT unroll rounds.
REQ-013 SHALL use FSM states IDLE, RUN, LAST, DONE.
REQ-014 in_ready SHALL equal (state==IDLE) OR (state==DONE AND out_ready).
REQ-015 Accept = in_valid AND in_ready: st <= data_in XOR key; rk <= key_step(key, RCON[0]); rnd <= 1; state -> RUN.
REQ-016 RUN, each cycle: st <= round(st, rk); rk <= key_step(rk, RCON[rnd]); rnd <= rnd+1; state -> LAST when rnd==9, else stays RUN.
REQ-017 LAST: st <= last_round(st, rk); state -> DONE.
REQ-018 DONE: out_valid=1, data_out=st held stable until out_ready=1.
REQ-019 DONE with out_ready=1 and no accept: state -> IDLE. With accept in the same cycle: state -> RUN directly and the new block is loaded.
REQ-020 Latency: out_valid rises exactly 10 cycles after the accept edge; the maximum rate is one block per 11 cycles.
REQ-021 data_in and key SHALL be sampled only at accept; later changes SHALL have no effect.
REQ-022 out_valid SHALL be 0 in IDLE/RUN/LAST; data_out SHALL be undefined-free (register value) in all states.
REQ-023 in_valid while in RUN/LAST SHALL be ignored and SHALL NOT be lost-accepted (in_ready=0).
REQ-024 rnd is 4 bits and SHALL never exceed 10; RCON indexing SHALL stay in range 0..9.

Reset
REQ-025 On rst_n=0: state=IDLE, st=0, rk=0, rnd=0, out_valid=0, data_out=0, busy=0, in_ready=0 while asserted.
REQ-026 Reset mid-operation SHALL discard the block in flight; no out_valid follows it.
REQ-027 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro AES_ITER_ABORT_EN, when defined, SHALL add input abort (1 bit): when high in RUN/LAST/DONE, state -> IDLE next cycle, out_valid -> 0, and the result is dropped; abort in IDLE has no effect and abort overrides a simultaneous accept.
REQ-029 Without AES_ITER_ABORT_EN: no abort port; behaviour exactly REQ-012..024.

Structure
REQ-030 Shared package aes_pkg SHALL hold the FSM state enum typedef, the RCON table (01,02,04,08,10,20,40,80,1b,36), and the constants AES_BLK_W=128 and AES_ROUNDS=10.
REQ-031 The one-step key schedule (RotWord, SubWord, RCON XOR, word chaining) SHALL be sub-module aes_key_step; the codebase round and last_round modules SHALL be instantiated once each.

Verification
REQ-032 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
REQ-033 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready held 0 for 5 cycles -> 3925841d02dc09fbdc118597196a0b32 stable throughout, in_ready=0.
REQ-034 Back-to-back: both vectors with in_valid held and out_ready=1 -> second accept in the DONE cycle of the first, results in order, 11-cycle spacing.
REQ-035 rst_n pulsed low at RUN rnd=5 -> all outputs zero, no out_valid afterwards, next block produces a correct result.
REQ-036 in_valid toggling with random data during RUN -> result unchanged; with AES_ITER_ABORT_EN, abort at rnd=3 -> IDLE next cycle, no out_valid.
